control_sequencer: RTL and testbench

//  Hardwired T-state control unit for the 32-bit bus CPU; replaces bench-driven control signals.

---
 rtl/control_sequencer_if.sv | 41 ++++
 rtl/control_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bundle between the T-state control sequencer and the CPU datapath/RAM.
// Inputs to the sequencer: run, IR, con_ff_bit.
// Outputs from the sequencer: all bus drivers, register loads, select/ALU controls, RAM strobes and status.
// The sequencer uses the master modport; the datapath side uses the slave modport.
interface control_sequencer_if;
   logic        run;
   logic [31:0] IR;
   logic        con_ff_bit;

   // bus drivers
   logic PCout, MDRout, HIout, LOout, Zhi_out, Zlo_out, Inport_out, Cout, BAout;
   // register loads
   logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, outport_in;
   // register select and ALU control
   logic Gra, Grb, Grc, Rout, IncPC;
   // RAM strobes
   logic Mem_Read, Mem_Write, Mem_enable512x32;
   // status
   logic [4:0]  opcode;
   logic [3:0]  t_state;
   logic        halted;
   logic        illegal_op;

   modport master (
      input  run, IR, con_ff_bit,
      output PCout, MDRout, HIout, LOout, Zhi_out, Zlo_out, Inport_out, Cout, BAout,
      output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, outport_in,
      output Gra, Grb, Grc, Rout, IncPC,
      output Mem_Read, Mem_Write, Mem_enable512x32,
      output opcode, t_state, halted, illegal_op
   );

   modport slave (
      output run, IR, con_ff_bit,
      input  PCout, MDRout, HIout, LOout, Zhi_out, Zlo_out, Inport_out, Cout, BAout,
      input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, outport_in,
      input  Gra, Grb, Grc, Rout, IncPC,
      input  Mem_Read, Mem_Write, Mem_enable512x32,
      input  opcode, t_state, halted, illegal_op
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch in T0-T2, then per-opcode execute steps decoded from IR[31:27].
// Ports: Clock (rising edge), clear (async active-low), bus (control_sequencer_if.master: run/IR/con_ff_bit in, strobes out).
// Optional CU_SINGLE_STEP_EN adds input step; with step=1 each finished instruction returns to IDLE and waits for run.
module control_sequencer #(
   parameter int MEM_LAT = 1,  // cycles a RAM strobe is held (1..15)
   parameter int OPC_W   = 5
) (
   input logic Clock,
   input logic clear,
`ifdef CU_SINGLE_STEP_EN
   input logic step,
`endif
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
      S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
      S_IDLE = 4'd8, S_HALT = 4'd9
   } state_t;

   localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(11);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(12);
   localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(14);
   localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(15);
   localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(16);
   localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(17);
   localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(18);
   localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(19);
   localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(21);
   localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(22);
   localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(23);
   localparam logic [OPC_W-1:0] OP_MFLO = OPC_W'(24);
   localparam logic [OPC_W-1:0] OP_MFHI = OPC_W'(25);
   localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(26);
   localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

   state_t           state, state_next;
   logic [3:0]       cnt, cnt_next;
   logic [OPC_W-1:0] op;
   logic             wait_last, done, mem_rd, mem_wr;
   logic             c_alu3, c_imm, c_mem, c_md, c_nn;
   logic             unused_ir;

   assign op        = bus.IR[31 -: OPC_W];
   assign unused_ir = ^bus.IR[31-OPC_W:0];
   assign wait_last = (cnt == 4'd0);

   // Opcode classes sharing the same step pattern
   assign c_alu3 = (op >= OP_ADD) && (op <= OP_SHL);
   assign c_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
   assign c_mem  = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   assign c_md   = (op == OP_MUL) || (op == OP_DIV);
   assign c_nn   = (op == OP_NEG) || (op == OP_NOT);

   // Steps that drive a RAM strobe and therefore dwell MEM_LAT cycles
   function automatic logic is_ram(input state_t s, input logic [OPC_W-1:0] o);
      return (s == S_T1) || (s == S_T6 && o == OP_LD) || (s == S_T7 && o == OP_ST);
   endfunction

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      done       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.HIout = 1'b0; bus.LOout = 1'b0;
      bus.Zhi_out = 1'b0; bus.Zlo_out = 1'b0; bus.Inport_out = 1'b0; bus.Cout = 1'b0;
      bus.BAout = 1'b0; bus.PCin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0;
      bus.IRin = 1'b0; bus.Yin = 1'b0; bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
      bus.Rin = 1'b0; bus.CONin = 1'b0; bus.outport_in = 1'b0;
      bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rout = 1'b0; bus.IncPC = 1'b0;
      bus.opcode = 5'd0;
      bus.illegal_op = 1'b0;

      case (state)
         S_IDLE: if (bus.run) state_next = S_T0;
         S_T0: begin
            bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            state_next = S_T1;
         end
         S_T1: begin
            bus.Zlo_out = 1'b1; mem_rd = 1'b1; bus.MDRin = 1'b1;
            bus.PCin = wait_last;  // incremented PC lands once, as the read completes
            if (wait_last) state_next = S_T2;
         end
         S_T2: begin
            bus.MDRout = 1'b1; bus.IRin = 1'b1;
            if (op == OP_HALT)     state_next = S_HALT;
            else if (op == OP_NOP) done = 1'b1;
            else                   state_next = S_T3;
         end
         S_T3: begin
            state_next = S_T4;
            if (c_alu3 || c_imm) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (c_mem) begin
               bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end else if (c_md) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (c_nn) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.opcode = op; bus.Zin = 1'b1;
            end else if (op == OP_BR) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
            end else begin
               done = 1'b1;
               if (op == OP_JR) begin
                  bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
               end else if (op == OP_IN) begin
                  bus.Inport_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
               end else if (op == OP_OUT) begin
                  bus.Gra = 1'b1; bus.Rout = 1'b1; bus.outport_in = 1'b1;
               end else if (op == OP_MFLO) begin
                  bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
               end else if (op == OP_MFHI) begin
                  bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
               end else begin
                  bus.illegal_op = 1'b1;
               end
            end
         end
         S_T4: begin
            state_next = S_T5;
            if (c_alu3) begin
               bus.Grc = 1'b1; bus.Rout = 1'b1; bus.opcode = op; bus.Zin = 1'b1;
            end else if (c_imm) begin
               bus.Cout = 1'b1; bus.opcode = op; bus.Zin = 1'b1;
            end else if (c_mem) begin
               bus.Cout = 1'b1; bus.opcode = OP_ADD; bus.Zin = 1'b1;
            end else if (c_md) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.opcode = op; bus.Zin = 1'b1;
            end else if (c_nn) begin
               bus.Zlo_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; done = 1'b1;
            end else if (op == OP_BR) begin
               bus.PCout = 1'b1; bus.Yin = 1'b1;
            end else begin
               done = 1'b1;
            end
         end
         S_T5: begin
            state_next = S_T6;
            if (c_alu3 || c_imm || op == OP_LDI) begin
               bus.Zlo_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; done = 1'b1;
            end else if (op == OP_LD || op == OP_ST) begin
               bus.Zlo_out = 1'b1; bus.MARin = 1'b1;
            end else if (c_md) begin
               bus.Zlo_out = 1'b1; bus.LOin = 1'b1;
            end else if (op == OP_BR) begin
               bus.Cout = 1'b1; bus.opcode = OP_ADD; bus.Zin = 1'b1;
            end else begin
               done = 1'b1;
            end
         end
         S_T6: begin
            if (op == OP_LD) begin
               mem_rd = 1'b1; bus.MDRin = 1'b1;
               if (wait_last) state_next = S_T7;
            end else if (op == OP_ST) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
               state_next = S_T7;
            end else if (c_md) begin
               bus.Zhi_out = 1'b1; bus.HIin = 1'b1; done = 1'b1;
            end else if (op == OP_BR) begin
               // branch target is already in Z; only its load into PC is conditional
               bus.Zlo_out = 1'b1; bus.PCin = bus.con_ff_bit; done = 1'b1;
            end else begin
               done = 1'b1;
            end
         end
         S_T7: begin
            if (op == OP_ST) begin
               mem_wr = 1'b1;
               if (wait_last) done = 1'b1;
            end else begin
               if (op == OP_LD) begin
                  bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
               end
               done = 1'b1;
            end
         end
         S_HALT: state_next = S_HALT;
         default: state_next = S_IDLE;
      endcase

`ifdef CU_SINGLE_STEP_EN
      if (done) state_next = step ? S_IDLE : S_T0;
`else
      if (done) state_next = S_T0;
`endif

      // Wait counter: load on entry to a RAM step, count down while dwelling
      if (is_ram(state_next, op) && state_next != state) cnt_next = 4'(MEM_LAT - 1);
      else if (is_ram(state, op) && state_next == state)  cnt_next = cnt - 4'd1;
      else                                                cnt_next = 4'd0;

      bus.Mem_Read         = mem_rd;
      bus.Mem_Write        = mem_wr;
      bus.Mem_enable512x32 = mem_rd | mem_wr;
      bus.halted           = (state == S_HALT);
      bus.t_state          = state[3] ? 4'd0 : state;
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: two instances, MEM_LAT=1 (dut1) and MEM_LAT=3 (dut3).
// Strobes are packed into a 30-bit vector per instance and compared with hand-built masks each cycle.
module tb_control_sequencer;

   logic Clock;
   logic clear;
   int   errors = 0;
   int   checks = 0;

   control_sequencer_if bus1 ();
   control_sequencer_if bus3 ();

`ifdef CU_SINGLE_STEP_EN
   logic step1, step3;
`endif

   control_sequencer #(.MEM_LAT(1), .OPC_W(5)) dut1 (
      .Clock(Clock), .clear(clear),
`ifdef CU_SINGLE_STEP_EN
      .step(step1),
`endif
      .bus(bus1.master));

   control_sequencer #(.MEM_LAT(3), .OPC_W(5)) dut3 (
      .Clock(Clock), .clear(clear),
`ifdef CU_SINGLE_STEP_EN
      .step(step3),
`endif
      .bus(bus3.master));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   localparam logic [29:0] M_PCOUT  = 30'd1 << 0;
   localparam logic [29:0] M_MDROUT = 30'd1 << 1;
   localparam logic [29:0] M_HIOUT  = 30'd1 << 2;
   localparam logic [29:0] M_LOOUT  = 30'd1 << 3;
   localparam logic [29:0] M_ZHI    = 30'd1 << 4;
   localparam logic [29:0] M_ZLO    = 30'd1 << 5;
   localparam logic [29:0] M_INPORT = 30'd1 << 6;
   localparam logic [29:0] M_COUT   = 30'd1 << 7;
   localparam logic [29:0] M_BAOUT  = 30'd1 << 8;
   localparam logic [29:0] M_PCIN   = 30'd1 << 9;
   localparam logic [29:0] M_MARIN  = 30'd1 << 10;
   localparam logic [29:0] M_MDRIN  = 30'd1 << 11;
   localparam logic [29:0] M_IRIN   = 30'd1 << 12;
   localparam logic [29:0] M_YIN    = 30'd1 << 13;
   localparam logic [29:0] M_ZIN    = 30'd1 << 14;
   localparam logic [29:0] M_HIIN   = 30'd1 << 15;
   localparam logic [29:0] M_LOIN   = 30'd1 << 16;
   localparam logic [29:0] M_RIN    = 30'd1 << 17;
   localparam logic [29:0] M_CONIN  = 30'd1 << 18;
   localparam logic [29:0] M_OUTIN  = 30'd1 << 19;
   localparam logic [29:0] M_GRA    = 30'd1 << 20;
   localparam logic [29:0] M_GRB    = 30'd1 << 21;
   localparam logic [29:0] M_GRC    = 30'd1 << 22;
   localparam logic [29:0] M_ROUT   = 30'd1 << 23;
   localparam logic [29:0] M_INCPC  = 30'd1 << 24;
   localparam logic [29:0] M_MEMRD  = 30'd1 << 25;
   localparam logic [29:0] M_MEMWR  = 30'd1 << 26;
   localparam logic [29:0] M_MEMEN  = 30'd1 << 27;
   localparam logic [29:0] M_HALTED = 30'd1 << 28;
   localparam logic [29:0] M_ILLEG  = 30'd1 << 29;

   localparam logic [29:0] F_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
   localparam logic [29:0] F_T1 = M_ZLO | M_MEMRD | M_MDRIN | M_MEMEN;
   localparam logic [29:0] F_T2 = M_MDROUT | M_IRIN;

   wire [29:0] obs1 = {bus1.illegal_op, bus1.halted, bus1.Mem_enable512x32, bus1.Mem_Write,
                       bus1.Mem_Read, bus1.IncPC, bus1.Rout, bus1.Grc, bus1.Grb, bus1.Gra,
                       bus1.outport_in, bus1.CONin, bus1.Rin, bus1.LOin, bus1.HIin, bus1.Zin,
                       bus1.Yin, bus1.IRin, bus1.MDRin, bus1.MARin, bus1.PCin, bus1.BAout,
                       bus1.Cout, bus1.Inport_out, bus1.Zlo_out, bus1.Zhi_out, bus1.LOout,
                       bus1.HIout, bus1.MDRout, bus1.PCout};
   wire [29:0] obs3 = {bus3.illegal_op, bus3.halted, bus3.Mem_enable512x32, bus3.Mem_Write,
                       bus3.Mem_Read, bus3.IncPC, bus3.Rout, bus3.Grc, bus3.Grb, bus3.Gra,
                       bus3.outport_in, bus3.CONin, bus3.Rin, bus3.LOin, bus3.HIin, bus3.Zin,
                       bus3.Yin, bus3.IRin, bus3.MDRin, bus3.MARin, bus3.PCin, bus3.BAout,
                       bus3.Cout, bus3.Inport_out, bus3.Zlo_out, bus3.Zhi_out, bus3.LOout,
                       bus3.HIout, bus3.MDRout, bus3.PCout};

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Full comparison of strobes, opcode and t_state for one instance
   task automatic chk(input int which, input string tag, input logic [29:0] es,
                      input logic [4:0] eop, input logic [3:0] ets);
      logic [38:0] o;
      logic [38:0] e;
      o = (which == 1) ? {obs1, bus1.opcode, bus1.t_state} : {obs3, bus3.opcode, bus3.t_state};
      e = {es, eop, ets};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Check a single strobe of dut1 against an expected level
   task automatic chk_bit1(input string tag, input logic [29:0] m, input logic ev);
      logic ob;
      ob = |(obs1 & m);
      checks++;
      assert (ob === ev) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, ob, ev);
      end
   endtask

   initial begin
      clear = 1'b0;
      bus1.run = 1'b0; bus1.IR = 32'h0; bus1.con_ff_bit = 1'b0;
      bus3.run = 1'b0; bus3.IR = 32'h0; bus3.con_ff_bit = 1'b0;
`ifdef CU_SINGLE_STEP_EN
      step1 = 1'b0; step3 = 1'b0;
`endif
      tick(); tick();
      chk(1, "reset1", 30'd0, 5'd0, 4'd0);
      chk(3, "reset3", 30'd0, 5'd0, 4'd0);
      clear = 1'b1;
      tick();
      chk(1, "idle1_norun", 30'd0, 5'd0, 4'd0);
      chk(3, "idle3_norun", 30'd0, 5'd0, 4'd0);

      // add R1,R2,R3 with MEM_LAT=1
      bus1.IR = 32'h18918000;
      bus1.run = 1'b1;
      tick(); chk(1, "add_T0", F_T0, 5'd0, 4'd0);
      bus1.run = 1'b0;
      tick(); chk(1, "add_T1", F_T1 | M_PCIN, 5'd0, 4'd1);
      tick(); chk(1, "add_T2", F_T2, 5'd0, 4'd2);
      tick(); chk(1, "add_T3", M_GRB | M_ROUT | M_YIN, 5'd0, 4'd3);
      tick(); chk(1, "add_T4", M_GRC | M_ROUT | M_ZIN, 5'd3, 4'd4);
      tick(); chk(1, "add_T5", M_ZLO | M_GRA | M_RIN, 5'd0, 4'd5);
      tick(); chk(1, "add_back_T0", F_T0, 5'd0, 4'd0);

      // asynchronous clear in the middle of T4
      tick(); tick(); tick(); tick();
      chk(1, "add2_T4", M_GRC | M_ROUT | M_ZIN, 5'd3, 4'd4);
      clear = 1'b0;
      #1;
      chk(1, "async_clear", 30'd0, 5'd0, 4'd0);
      tick();
      clear = 1'b1;
      tick(); chk(1, "idle_after_clear", 30'd0, 5'd0, 4'd0);

      // ld with MEM_LAT=3
      bus3.IR = 32'h00800000;
      bus3.run = 1'b1;
      tick(); chk(3, "ld_T0", F_T0, 5'd0, 4'd0);
      bus3.run = 1'b0;
      tick(); chk(3, "ld_T1_w2", F_T1, 5'd0, 4'd1);
      tick(); chk(3, "ld_T1_w1", F_T1, 5'd0, 4'd1);
      tick(); chk(3, "ld_T1_w0", F_T1 | M_PCIN, 5'd0, 4'd1);
      tick(); chk(3, "ld_T2", F_T2, 5'd0, 4'd2);
      tick(); chk(3, "ld_T3", M_GRB | M_BAOUT | M_YIN, 5'd0, 4'd3);
      tick(); chk(3, "ld_T4", M_COUT | M_ZIN, 5'd3, 4'd4);
      tick(); chk(3, "ld_T5", M_ZLO | M_MARIN, 5'd0, 4'd5);
      for (int i = 0; i < 3; i++) begin
         tick(); chk(3, "ld_T6_wait", M_MEMRD | M_MDRIN | M_MEMEN, 5'd0, 4'd6);
      end
      tick(); chk(3, "ld_T7", M_MDROUT | M_GRA | M_RIN, 5'd0, 4'd7);
      tick(); chk(3, "ld_back_T0", F_T0, 5'd0, 4'd0);

      // br not taken, then taken
      bus1.IR = 32'h98000000;
      bus1.con_ff_bit = 1'b0;
      bus1.run = 1'b1;
      tick(); chk(1, "br_T0", F_T0, 5'd0, 4'd0);
      bus1.run = 1'b0;
      tick(); tick();
      tick(); chk(1, "br_T3", M_GRA | M_ROUT | M_CONIN, 5'd0, 4'd3);
      tick(); chk(1, "br_T4", M_PCOUT | M_YIN, 5'd0, 4'd4);
      tick(); chk(1, "br_T5", M_COUT | M_ZIN, 5'd3, 4'd5);
      tick(); chk_bit1("br_nt_T6_pcin", M_PCIN, 1'b0);
      tick(); chk(1, "br_nt_next_T0", F_T0, 5'd0, 4'd0);
      bus1.con_ff_bit = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      tick(); chk(1, "br_tk_T6", M_ZLO | M_PCIN, 5'd0, 4'd6);
      tick(); chk(1, "br_tk_next_T0", F_T0, 5'd0, 4'd0);

      // undefined opcode 11111
      bus1.IR = 32'hF8000000;
      tick(); tick();
      tick(); chk(1, "illegal_T3", M_ILLEG, 5'd0, 4'd3);
      tick(); chk(1, "illegal_after", F_T0, 5'd0, 4'd0);

      // halt 11011 with run toggling
      bus1.IR = 32'hD8000000;
      tick();
      tick(); chk(1, "halt_T2", F_T2, 5'd0, 4'd2);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk(1, "halt_hold", M_HALTED, 5'd0, 4'd0);
         bus1.run = i[0];
      end
      bus1.run = 1'b0;
      clear = 1'b0;
      tick();
      chk(1, "halt_cleared", 30'd0, 5'd0, 4'd0);
      chk(3, "dut3_cleared", 30'd0, 5'd0, 4'd0);
      clear = 1'b1;

`ifdef CU_SINGLE_STEP_EN
      // one instruction per run pulse
      step1 = 1'b1;
      bus1.IR = 32'h18918000;
      for (int k = 0; k < 2; k++) begin
         bus1.run = 1'b1;
         tick(); chk(1, "ss_T0", F_T0, 5'd0, 4'd0);
         bus1.run = 1'b0;
         tick(); tick(); tick(); tick();
         tick(); chk(1, "ss_T5", M_ZLO | M_GRA | M_RIN, 5'd0, 4'd5);
         tick(); chk(1, "ss_idle_a", 30'd0, 5'd0, 4'd0);
         tick(); chk(1, "ss_idle_b", 30'd0, 5'd0, 4'd0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
